// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg
//   Shared definitions for the countdown timer (and the stopwatch digit
//   registers): FSM state encoding, digit register control codes, the
//   blank display pattern, seven-segment digit constants and small helpers.
//   Seven-segment patterns are active-low, bit0 = a ... bit6 = g.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  // Control codes understood by the shared digit register.
  typedef enum logic [2:0] {
    REG_NONE = 3'd0,
    REG_CLR  = 3'd1,
    REG_LOAD = 3'd2,
    REG_INCR = 3'd3,
    REG_DECR = 3'd4
  } reg_ctrl_t;

  localparam logic [7:0] BLANK = 8'hFF;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [3:0] BCD_NINE          = 4'd9;
  // Blink counter phases 5..9 blank the display.
  localparam logic [3:0] BLINK_BLANK_FIRST = 4'd5;

  // Seven-segment encoder shared with the stopwatch display path.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  // Clamp a preset nibble to a legal BCD digit.
  function automatic logic [3:0] bcd_sat(input logic [3:0] nib);
    return (nib > BCD_NINE) ? BCD_NINE : nib;
  endfunction

  // Modulo-10 increment used by the decade dividers and blink counter.
  function automatic logic [3:0] decade_next(input logic [3:0] d);
    return (d >= BCD_NINE) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/countdown_timer_reg.sv
// countdown_timer_reg
//   Generic control-coded register shared with the stopwatch digits.
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset (clears q)
//     ctrl   in   REG_NONE / REG_CLR / REG_LOAD / REG_INCR / REG_DECR
//     din    in   WIDTH-bit load value
//     q      out  WIDTH-bit register value
//   INCR/DECR are plain binary +/-1; BCD wrap is the caller's business.
module countdown_timer_reg
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  reg_ctrl_t        ctrl,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    case (ctrl)
      REG_CLR:  q_d = '0;
      REG_LOAD: q_d = din;
      REG_INCR: q_d = q_q + WIDTH'(1);
      REG_DECR: q_d = q_q - WIDTH'(1);
      default:  q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/countdown_timer_tick_gen.sv
// tick_gen
//   Prescaler producing 1 ms / 10 ms / 100 ms / 1 s single-cycle strobes.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     restart      clear prescaler and all decade phases
//     run          advance the phase; low freezes it (pause)
//     tick_1ms     one cycle every TICK_DIV cycles while running
//     tick_10ms / tick_100ms / tick_1s
//                  decade divisions, always coincident with tick_1ms
//   The strobes are combinational from the phase registers so a consumer
//   acting on a strobe updates on the same edge that wraps the phase.
module tick_gen
  import countdown_timer_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic tick_1ms,
  output logic tick_10ms,
  output logic tick_100ms,
  output logic tick_1s
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] PRE_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] pre_q, pre_d;
  logic [3:0]    dec10_q, dec10_d;
  logic [3:0]    dec100_q, dec100_d;
  logic [3:0]    dec1s_q, dec1s_d;

  always_comb begin
    tick_1ms   = run && (pre_q == PRE_LAST);
    tick_10ms  = tick_1ms   && (dec10_q  == BCD_NINE);
    tick_100ms = tick_10ms  && (dec100_q == BCD_NINE);
    tick_1s    = tick_100ms && (dec1s_q  == BCD_NINE);
  end

  always_comb begin
    pre_d    = pre_q;
    dec10_d  = dec10_q;
    dec100_d = dec100_q;
    dec1s_d  = dec1s_q;
    if (restart) begin
      pre_d    = '0;
      dec10_d  = '0;
      dec100_d = '0;
      dec1s_d  = '0;
    end else if (run) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + CW'(1);
      if (tick_1ms)   dec10_d  = decade_next(dec10_q);
      if (tick_10ms)  dec100_d = decade_next(dec100_q);
      if (tick_100ms) dec1s_d  = decade_next(dec1s_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      dec10_q  <= '0;
      dec100_q <= '0;
      dec1s_q  <= '0;
    end else begin
      pre_q    <= pre_d;
      dec10_q  <= dec10_d;
      dec100_q <= dec100_d;
      dec1s_q  <= dec1s_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer
//   Four-digit BCD countdown timer with selectable resolution and a blinking
//   expiry indication. Display format matches the stopwatch.
//   Ports:
//     clk                 rising-edge clock
//     rst                 asynchronous active-low reset
//     decimal_places[1:0] resolution 0=1 s, 1=0.1 s, 2=0.01 s, 3=0.001 s
//     set_value[15:0]     preset, four BCD digits, [3:0] least significant
//     load/start/pause/stop  single-cycle control pulses
//     display0..3[7:0]    {dot, seg[6:0]} active-low, 8'hFF = blank
//     pause_indicator     high while PAUSED
//     expired             high while EXPIRED
//   Build option: COUNTDOWN_AUTO_RELOAD_EN -- reaching 0000 pulses expired
//   for one cycle and the next strobe reloads the preset instead of
//   entering EXPIRED (a zero preset still expires).
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  decimal_places,
  input  logic [15:0] set_value,
  input  logic        load,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
  output logic [7:0]  display0,
  output logic [7:0]  display1,
  output logic [7:0]  display2,
  output logic [7:0]  display3,
  output logic        pause_indicator,
  output logic        expired
);

  state_t      state_q, state_d;
  logic [1:0]  dp_q, dp_d;
  logic [15:0] reload_q, reload_d;
  logic [3:0]  blink_q, blink_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic        wrap_q, wrap_d;
`endif

  logic [3:0][3:0] digit;
  reg_ctrl_t       dig_ctrl [4];
  logic [3:0]      dig_din  [4];
  reg_ctrl_t       dec_ctrl [4];
  logic [15:0]     value;
  logic [15:0]     set_sat;
  logic            restart, run, strobe, expiring, blank_all;
  logic            tick_1ms, tick_10ms, tick_100ms, tick_1s;

  for (genvar g = 0; g < 4; g++) begin : g_digit
    countdown_timer_reg #(.WIDTH(4)) u_digit (
      .clk   (clk),
      .rst_n (rst),
      .ctrl  (dig_ctrl[g]),
      .din   (dig_din[g]),
      .q     (digit[g])
    );
  end

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk        (clk),
    .rst_n      (rst),
    .restart    (restart),
    .run        (run),
    .tick_1ms   (tick_1ms),
    .tick_10ms  (tick_10ms),
    .tick_100ms (tick_100ms),
    .tick_1s    (tick_1s)
  );

  // The tick phase only advances while counting or blinking.
  assign run   = (state_q == ST_RUNNING) || (state_q == ST_EXPIRED);
  assign value = digit;

  always_comb begin
    case (dp_q)
      2'd0:    strobe = tick_1s;
      2'd1:    strobe = tick_100ms;
      2'd2:    strobe = tick_10ms;
      default: strobe = tick_1ms;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) set_sat[i*4 +: 4] = bcd_sat(set_value[i*4 +: 4]);
  end

  // BCD decrement: every digit below the first nonzero one is 0 and
  // becomes 9 (loaded); the first nonzero digit decrements; higher hold.
  always_comb begin
    logic lower_zero;
    lower_zero = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dec_ctrl[i] = REG_NONE;
      if (lower_zero) dec_ctrl[i] = (digit[i] == 4'd0) ? REG_LOAD : REG_DECR;
      lower_zero = lower_zero && (digit[i] == 4'd0);
    end
  end

  always_comb begin
    state_d  = state_q;
    dp_d     = dp_q;
    reload_d = reload_q;
    blink_d  = blink_q;
    restart  = 1'b0;
    expiring = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    wrap_d   = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      dig_ctrl[i] = REG_NONE;
      dig_din[i]  = '0;
    end

    case (state_q)
      ST_IDLE: begin
        dp_d = decimal_places;
        if (load) begin
          reload_d = set_sat;
          for (int i = 0; i < 4; i++) begin
            dig_ctrl[i] = REG_LOAD;
            dig_din[i]  = set_sat[i*4 +: 4];
          end
        end
        if (start && (value != 16'h0000)) begin
          restart = 1'b1;
          state_d = ST_RUNNING;
        end
      end

      ST_RUNNING: begin
        if (strobe) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if (value == 16'h0000) begin
            for (int i = 0; i < 4; i++) begin
              dig_ctrl[i] = REG_LOAD;
              dig_din[i]  = reload_q[i*4 +: 4];
            end
          end else begin
            for (int i = 0; i < 4; i++) begin
              dig_ctrl[i] = dec_ctrl[i];
              dig_din[i]  = BCD_NINE;
            end
            // 0001 is the last value before zero.
            if (value == 16'h0001) begin
              if (reload_q == 16'h0000) expiring = 1'b1;
              else                      wrap_d   = 1'b1;
            end
          end
`else
          for (int i = 0; i < 4; i++) begin
            dig_ctrl[i] = dec_ctrl[i];
            dig_din[i]  = BCD_NINE;
          end
          // 0001 is the last value before zero.
          if (value == 16'h0001) expiring = 1'b1;
`endif
        end
        // Expiry overrides a coincident pause/stop.
        if (expiring) begin
          state_d = ST_EXPIRED;
        end else if (pause) begin
          state_d = ST_PAUSED;
        end else if (stop) begin
          state_d = ST_IDLE;
          for (int i = 0; i < 4; i++) begin
            dig_ctrl[i] = REG_LOAD;
            dig_din[i]  = reload_q[i*4 +: 4];
          end
        end
      end

      ST_PAUSED: begin
        if (start) begin
          state_d = ST_RUNNING;
        end else if (stop) begin
          state_d = ST_IDLE;
          for (int i = 0; i < 4; i++) begin
            dig_ctrl[i] = REG_LOAD;
            dig_din[i]  = reload_q[i*4 +: 4];
          end
        end
      end

      ST_EXPIRED: begin
        if (tick_100ms) blink_d = decade_next(blink_q);
        if (stop) begin
          state_d = ST_IDLE;
          blink_d = '0;
          for (int i = 0; i < 4; i++) begin
            dig_ctrl[i] = REG_LOAD;
            dig_din[i]  = reload_q[i*4 +: 4];
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      dp_q     <= '0;
      reload_q <= '0;
      blink_q  <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      wrap_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      dp_q     <= dp_d;
      reload_q <= reload_d;
      blink_q  <= blink_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      wrap_q   <= wrap_d;
`endif
    end
  end

  always_comb begin
    pause_indicator = (state_q == ST_PAUSED);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    expired         = (state_q == ST_EXPIRED) || wrap_q;
`else
    expired         = (state_q == ST_EXPIRED);
`endif
    blank_all = (state_q == ST_EXPIRED) && (blink_q >= BLINK_BLANK_FIRST);
    // Dot bit is active-low: lit (0) on the digit selected by dp_q.
    display0 = blank_all ? BLANK : {dp_q != 2'd0, seg_encode(digit[0])};
    display1 = blank_all ? BLANK : {dp_q != 2'd1, seg_encode(digit[1])};
    display2 = blank_all ? BLANK : {dp_q != 2'd2, seg_encode(digit[2])};
    display3 = blank_all ? BLANK : {dp_q != 2'd3, seg_encode(digit[3])};
  end

endmodule
